// File: rtl/run_ctrl.sv
// Run controller for the rv32i core: holds the core reset domains, releases them
// one after another, runs until halt or budget expiry, and reports cycle/retire counts.
module run_ctrl #(
  parameter int NUM_RST     = 2,
  parameter int HOLD_CYCLES = 4,
  parameter int STAGGER     = 2,
  parameter int MAX_CYCLES  = 25,
  parameter int AUTO_START  = 1,
  parameter int CNT_W       = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               halt,
  input  logic               retire,
  output logic [NUM_RST-1:0] core_rst_n,
  output logic               running,
  output logic               done,
  output logic               timeout,
  output logic [CNT_W-1:0]   cycles,
  output logic [CNT_W-1:0]   instret
);

  localparam int MAX_DLY = (HOLD_CYCLES > STAGGER) ? HOLD_CYCLES : STAGGER;
  localparam int TMR_W   = (MAX_DLY > 1) ? $clog2(MAX_DLY) : 1;
  localparam int IDX_W   = (NUM_RST > 1) ? $clog2(NUM_RST) : 1;

  localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'(HOLD_CYCLES - 1);
  localparam logic [TMR_W-1:0] STAG_LOAD = TMR_W'(STAGGER - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_RST - 1);
  localparam logic [63:0]      BUDGET    = 64'(MAX_CYCLES);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HOLD,
    ST_RELEASE,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [IDX_W-1:0]   rel_idx_q, rel_idx_d;
  logic [NUM_RST-1:0] core_rst_n_q, core_rst_n_d;
  logic               running_q, running_d;
  logic               done_q, done_d;
  logic               timeout_q, timeout_d;
  logic [CNT_W-1:0]   cycles_q, cycles_d;
  logic [CNT_W-1:0]   instret_q, instret_d;

  logic [63:0]        cyc_ext;
  logic               budget_hit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Compared in a wide domain so a saturated counter never aliases onto the budget.
  assign cyc_ext    = 64'(cycles_q);
  assign budget_hit = (MAX_CYCLES != 0) && ((cyc_ext + 64'd1) == BUDGET);

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    rel_idx_d    = rel_idx_q;
    core_rst_n_d = core_rst_n_q;
    running_d    = running_q;
    done_d       = done_q;
    timeout_d    = timeout_q;
    cycles_d     = cycles_q;
    instret_d    = instret_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start || (AUTO_START != 0)) begin
          state_d      = ST_HOLD;
          timer_d      = HOLD_LOAD;
          rel_idx_d    = '0;
          core_rst_n_d = '0;
          done_d       = 1'b0;
          timeout_d    = 1'b0;
          cycles_d     = '0;
          instret_d    = '0;
        end
      end

      ST_HOLD: begin
        if (timer_q == '0) begin
          core_rst_n_d[0] = 1'b1;
          if (NUM_RST == 1) begin
            state_d   = ST_RUN;
            running_d = 1'b1;
          end else begin
            state_d   = ST_RELEASE;
            rel_idx_d = IDX_W'(1);
            timer_d   = STAG_LOAD;
          end
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end

      ST_RELEASE: begin
        if (timer_q == '0) begin
          core_rst_n_d[rel_idx_q] = 1'b1;
          if (rel_idx_q == LAST_IDX) begin
            state_d   = ST_RUN;
            running_d = 1'b1;
          end else begin
            rel_idx_d = rel_idx_q + IDX_W'(1);
            timer_d   = STAG_LOAD;
          end
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end

      ST_RUN: begin
        // The exiting edge still counts, so the increments are unconditional here.
        cycles_d = sat_inc(cycles_q);
        if (retire) begin
          instret_d = sat_inc(instret_q);
        end
        if (halt) begin
          state_d      = ST_DONE;
          done_d       = 1'b1;
          running_d    = 1'b0;
          core_rst_n_d = '0;
        end else if (budget_hit) begin
          state_d      = ST_DONE;
          timeout_d    = 1'b1;
          running_d    = 1'b0;
          core_rst_n_d = '0;
        end
      end

      ST_DONE: begin
        if (start) begin
          state_d      = ST_HOLD;
          timer_d      = HOLD_LOAD;
          rel_idx_d    = '0;
          core_rst_n_d = '0;
          done_d       = 1'b0;
          timeout_d    = 1'b0;
          cycles_d     = '0;
          instret_d    = '0;
        end
      end

      default: begin
        state_d      = ST_IDLE;
        core_rst_n_d = '0;
        running_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      timer_q      <= '0;
      rel_idx_q    <= '0;
      core_rst_n_q <= '0;
      running_q    <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      cycles_q     <= '0;
      instret_q    <= '0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      rel_idx_q    <= rel_idx_d;
      core_rst_n_q <= core_rst_n_d;
      running_q    <= running_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
      cycles_q     <= cycles_d;
      instret_q    <= instret_d;
    end
  end

  assign core_rst_n = core_rst_n_q;
  assign running    = running_q;
  assign done       = done_q;
  assign timeout    = timeout_q;
  assign cycles     = cycles_q;
  assign instret    = instret_q;

endmodule

// File: tb/tb_run_ctrl.sv
// Bench for run_ctrl: two configurations driven by directed then random stimulus,
// checked every cycle against a time-since-start model of the release schedule.
module tb_run_ctrl;

  logic clk;
  logic rst;
  logic start_a, halt_a, retire_a;
  logic start_b, halt_b, retire_b;

  logic [1:0]  core_a;
  logic        running_a, done_a, timeout_a;
  logic [31:0] cycles_a, instret_a;

  logic [3:0]  core_b;
  logic        running_b, done_b, timeout_b;
  logic [3:0]  cycles_b, instret_b;

  int vectors;
  int miscompares;
  int edge_no;
  bit cmp_en;

  run_ctrl u_dut_a (
    .clk        (clk),
    .rst        (rst),
    .start      (start_a),
    .halt       (halt_a),
    .retire     (retire_a),
    .core_rst_n (core_a),
    .running    (running_a),
    .done       (done_a),
    .timeout    (timeout_a),
    .cycles     (cycles_a),
    .instret    (instret_a)
  );

  run_ctrl #(
    .NUM_RST    (4),
    .HOLD_CYCLES(4),
    .STAGGER    (3),
    .MAX_CYCLES (0),
    .AUTO_START (1),
    .CNT_W      (4)
  ) u_dut_b (
    .clk        (clk),
    .rst        (rst),
    .start      (start_b),
    .halt       (halt_b),
    .retire     (retire_b),
    .core_rst_n (core_b),
    .running    (running_b),
    .done       (done_b),
    .timeout    (timeout_b),
    .cycles     (cycles_b),
    .instret    (instret_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // phase: 0 waiting for a start, 1 sequencing/running, 2 ended.
  // k counts edges since the start edge; everything else follows from it.
  typedef struct packed {
    int     phase;
    int     k;
    longint cyc;
    longint ins;
    logic   dn;
    logic   to;
  } mdl_t;

  mdl_t ma, mb;

  function automatic mdl_t mrestart();
    mdl_t n;
    n = '0;
    n.phase = 1;
    return n;
  endfunction

  function automatic mdl_t mstep(input mdl_t m, input int nrst, input int hold, input int stag,
                                 input int maxc, input int autos, input int w,
                                 input logic st, input logic h, input logic r);
    mdl_t   n;
    longint top;
    int     trun;
    n    = m;
    top  = (longint'(1) << w) - 1;
    trun = hold + (nrst - 1) * stag;
    if (m.phase == 0) begin
      if (st || autos != 0) n = mrestart();
    end else if (m.phase == 1) begin
      n.k = m.k + 1;
      if (m.k >= trun) begin
        n.cyc = (m.cyc + 1 > top) ? top : m.cyc + 1;
        if (r) n.ins = (m.ins + 1 > top) ? top : m.ins + 1;
        if (h) begin
          n.phase = 2;
          n.dn    = 1'b1;
        end else if (maxc != 0 && m.cyc + 1 == longint'(maxc)) begin
          n.phase = 2;
          n.to    = 1'b1;
        end
      end
    end else begin
      if (st) n = mrestart();
    end
    return n;
  endfunction

  function automatic logic [63:0] mcore(input mdl_t m, input int nrst, input int hold, input int stag);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < nrst; i++) begin
      if (m.phase == 1 && m.k >= hold + i * stag) v[i] = 1'b1;
    end
    return v;
  endfunction

  function automatic logic mrun(input mdl_t m, input int nrst, input int hold, input int stag);
    return (m.phase == 1) && (m.k >= hold + (nrst - 1) * stag);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ma <= '0;
      mb <= '0;
    end else begin
      ma <= mstep(ma, 2, 4, 2, 25, 1, 32, start_a, halt_a, retire_a);
      mb <= mstep(mb, 4, 4, 3, 0, 1, 4, start_b, halt_b, retire_b);
    end
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) edge_no <= 0;
    else      edge_no <= edge_no + 1;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at edge %0d: got %0h, expected %0h", nm, edge_no, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("a_core_rst_n", 64'(core_a),    mcore(ma, 2, 4, 2));
      chk("a_running",    64'(running_a), 64'(mrun(ma, 2, 4, 2)));
      chk("a_done",       64'(done_a),    64'(ma.dn));
      chk("a_timeout",    64'(timeout_a), 64'(ma.to));
      chk("a_cycles",     64'(cycles_a),  64'(ma.cyc));
      chk("a_instret",    64'(instret_a), 64'(ma.ins));
      chk("b_core_rst_n", 64'(core_b),    mcore(mb, 4, 4, 3));
      chk("b_running",    64'(running_b), 64'(mrun(mb, 4, 4, 3)));
      chk("b_done",       64'(done_b),    64'(mb.dn));
      chk("b_timeout",    64'(timeout_b), 64'(mb.to));
      chk("b_cycles",     64'(cycles_b),  64'(mb.cyc));
      chk("b_instret",    64'(instret_b), 64'(mb.ins));
    end
  end

  // Returns 1 time unit after edge n, so outputs of that edge are settled.
  task automatic at_edge(input int n);
    int guard;
    guard = 0;
    while (edge_no < n && guard < 500) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (edge_no < n) begin
      vectors++;
      miscompares++;
      $display("FAIL at_edge: reached edge %0d, required %0d", edge_no, n);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_a_core"},  64'(core_a),    64'd0);
    chk({tag, "_a_run"},   64'(running_a), 64'd0);
    chk({tag, "_a_done"},  64'(done_a),    64'd0);
    chk({tag, "_a_to"},    64'(timeout_a), 64'd0);
    chk({tag, "_a_cyc"},   64'(cycles_a),  64'd0);
    chk({tag, "_a_ins"},   64'(instret_a), 64'd0);
    chk({tag, "_b_core"},  64'(core_b),    64'd0);
    chk({tag, "_b_cyc"},   64'(cycles_b),  64'd0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    cmp_en      = 1'b1;
    rst         = 1'b0;
    start_a = 1'b0; halt_a = 1'b0; retire_a = 1'b0;
    start_b = 1'b0; halt_b = 1'b0; retire_b = 1'b1;

    repeat (2) @(posedge clk);
    #1 chk_reset_vals("reset");
    #2 rst = 1'b1;

    // Budget run on A, saturating unlimited run on B.
    at_edge(4);  chk("a_core_e4", 64'(core_a), 64'b00);
    at_edge(5);  chk("a_core_e5", 64'(core_a), 64'b01);
                 chk("b_core_e5", 64'(core_b), 64'b0001);
    at_edge(6);  chk("a_run_e6",  64'(running_a), 64'd0);
    at_edge(7);  chk("a_core_e7", 64'(core_a), 64'b11);
                 chk("a_run_e7",  64'(running_a), 64'd1);
    at_edge(8);  chk("b_core_e8", 64'(core_b), 64'b0011);
    at_edge(11); chk("b_core_e11", 64'(core_b), 64'b0111);
    at_edge(14); chk("b_core_e14", 64'(core_b), 64'b1111);
                 chk("b_run_e14",  64'(running_b), 64'd1);
    at_edge(29); chk("b_cyc_e29", 64'(cycles_b), 64'd15);
                 chk("b_ins_e29", 64'(instret_b), 64'd15);
    at_edge(31); chk("a_to_e31",  64'(timeout_a), 64'd0);
                 chk("a_cyc_e31", 64'(cycles_a), 64'd24);
    at_edge(32); chk("a_to_e32",  64'(timeout_a), 64'd1);
                 chk("a_done_e32", 64'(done_a), 64'd0);
                 chk("a_cyc_e32", 64'(cycles_a), 64'd25);
                 chk("a_core_e32", 64'(core_a), 64'b00);
                 chk("a_run_e32", 64'(running_a), 64'd0);
    at_edge(40); chk("b_cyc_e40", 64'(cycles_b), 64'd15);
                 chk("b_to_e40",  64'(timeout_b), 64'd0);

    // Restart A at edge 45; RUN entered at 51, halt on the 10th RUN edge (61).
    at_edge(44); #1 start_a = 1'b1;
    at_edge(45); start_a = 1'b0;
    chk("a_done_s",  64'(done_a), 64'd0);
    chk("a_to_s",    64'(timeout_a), 64'd0);
    chk("a_cyc_s",   64'(cycles_a), 64'd0);
    at_edge(48); chk("a_core_s3", 64'(core_a), 64'b00);
    at_edge(49); chk("a_core_s4", 64'(core_a), 64'b01);
    for (int e = 51; e <= 60; e++) begin
      at_edge(e);
      #1;
      retire_a = ((e - 51) % 2 == 0);
      start_a  = (e == 55);
      halt_a   = (e == 60);
    end
    at_edge(61);
    halt_a = 1'b0; retire_a = 1'b1; start_a = 1'b0;
    chk("a_done_h",  64'(done_a), 64'd1);
    chk("a_to_h",    64'(timeout_a), 64'd0);
    chk("a_cyc_h",   64'(cycles_a), 64'd10);
    chk("a_ins_h",   64'(instret_a), 64'd5);
    chk("a_core_h",  64'(core_a), 64'b00);
    at_edge(66); chk("a_cyc_frz", 64'(cycles_a), 64'd10);
                 chk("a_ins_frz", 64'(instret_a), 64'd5);

    // Async reset while A is mid-release.
    at_edge(69); #1 start_a = 1'b1;
    at_edge(70); start_a = 1'b0;
    at_edge(75); chk("a_core_pre", 64'(core_a), 64'b01);
    #2 rst = 1'b0;
    #1 chk_reset_vals("async");
    #2 rst = 1'b1;
    at_edge(5); chk("a_core_re5", 64'(core_a), 64'b01);
    at_edge(7); chk("a_core_re7", 64'(core_a), 64'b11);

    // Halt on the budget edge: halt wins.
    at_edge(31); #1 halt_a = 1'b1;
    at_edge(32); halt_a = 1'b0;
    chk("a_done_hb", 64'(done_a), 64'd1);
    chk("a_to_hb",   64'(timeout_a), 64'd0);
    chk("a_cyc_hb",  64'(cycles_a), 64'd25);
    chk("a_ins_hb",  64'(instret_a), 64'd25);

    // Random traffic, with occasional asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #2;
      start_a  = ($urandom_range(0, 19) == 0);
      halt_a   = ($urandom_range(0, 29) == 0);
      retire_a = $urandom_range(0, 1);
      start_b  = ($urandom_range(0, 9) == 0);
      halt_b   = ($urandom_range(0, 39) == 0);
      retire_b = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 399) == 0) begin
        #1 rst = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
      end
    end

    @(posedge clk);
    #2 cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/run_ctrl.md
# run_ctrl

Synthesizable run controller for the rv32i pipelined core, and the parametrised successor to the fixed reset-then-run sequence used in simulation. It holds one or more core reset domains in reset, releases them one after another, and lets the core run. It ends the run on a halt indication from the core or when a cycle budget expires, then reports cycle and retired-instruction counts. It sits between the board/bench reset and the core's reset inputs.

## Interface
- NUM_RST, 2, number of staged core reset outputs (≥1)
- HOLD_CYCLES, 4, cycles all core resets stay asserted after a (re)start (≥1)
- STAGGER, 2, cycles between successive reset-bit releases (≥1)
- MAX_CYCLES, 25, RUN-cycle budget; 0 = unlimited
- AUTO_START, 1, 1 = start automatically on the first edge after reset deassertion
- CNT_W, 32, counter width

- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  start/restart request, sampled in IDLE and DONE only
- halt  in  1  core signals ecall/ebreak retired; sampled in RUN only
- retire  in  1  one instruction retired this cycle
- core_rst_n  out  NUM_RST  active-low resets to core domains; bit 0 is released first
- running  out  1  high while in RUN
- done  out  1  run ended by halt (sticky until restart)
- timeout  out  1  run ended by budget expiry (sticky until restart)
- cycles  out  CNT_W  RUN cycles elapsed
- instret  out  CNT_W  instructions retired during RUN

## Operation
- All outputs are registered. Reset values: state IDLE, core_rst_n all 0, running 0, done 0, timeout 0, cycles 0, instret 0.
- rst low forces the reset values asynchronously, including mid-run. core_rst_n drops to 0 immediately.
- States and transitions:
  - **IDLE:** go to HOLD on start=1, or unconditionally on the first edge if AUTO_START=1.
  - **HOLD:** all core_rst_n stay 0 for HOLD_CYCLES edges. On the last edge, set core_rst_n[0]=1. Go to RUN if NUM_RST=1, otherwise go to RELEASE.
  - **RELEASE:** core_rst_n[i] rises STAGGER edges after core_rst_n[i-1]. On the edge that releases the last bit, go to RUN and set running=1.
  - **RUN:** on each edge, cycles increments and instret increments if retire=1. Exit rules, in priority order:
    - halt=1 → DONE with done=1.
    - Otherwise, if MAX_CYCLES≠0 and cycles+1==MAX_CYCLES → DONE with timeout=1.
    - The exiting edge still counts the cycle, and counts retire if asserted.
  - **DONE:** running=0, all core_rst_n=0 (core frozen), counters frozen. start=1 → HOLD, clearing done, timeout, cycles and instret on that edge.
- Entering HOLD from IDLE also clears the counters.
- Simultaneous events:
  - halt and budget expiry on the same edge → done=1, timeout=0.
  - start during HOLD, RELEASE or RUN is ignored.
  - halt or retire outside RUN is ignored.
- cycles and instret saturate at all-ones and never wrap.
- done and timeout are never both 1.

## Timing
- Edge numbering: edge k is the k-th rising edge after rst rises, or the edge at which start is sampled.
- With AUTO_START=1:
  - HOLD is entered at edge 1.
  - core_rst_n[i] rises at edge 1+HOLD_CYCLES+i·STAGGER.
  - running rises together with the last bit, at edge 1+HOLD_CYCLES+(NUM_RST-1)·STAGGER.
- With start sampled at edge s: releases occur at s+HOLD_CYCLES+i·STAGGER.
- Run length:
  - Budget exit occurs MAX_CYCLES edges after RUN entry, with cycles==MAX_CYCLES.
  - Halt exit at the j-th RUN edge gives cycles==j.
- done, timeout, running and the core_rst_n drop all change on the same exit edge.

## Test plan
- Default params, AUTO_START=1, halt=0:
  - core_rst_n goes 00→01 at edge 5 and 01→11 at edge 7; running=1 from edge 7.
  - At edge 32: timeout=1, cycles=25, core_rst_n=00, running=0.
- Default params with retire=1 on every other RUN cycle, and halt pulsed on the 10th RUN edge:
  - done=1, timeout=0, cycles=10, instret=5, counters then frozen.
- Halt and budget on the same edge (MAX_CYCLES=3, halt on the 3rd RUN edge):
  - done=1, timeout=0, cycles=3.
- From DONE, pulse start=1 at edge s:
  - done, timeout and counters clear at s; core_rst_n[0] rises at s+4.
  - start pulsed during RUN has no effect.
- Drive rst low mid-RELEASE (core_rst_n=01):
  - All outputs return to reset values immediately, without waiting for a clock edge.
  - After rst rises, the sequence restarts from edge 1.
- NUM_RST=4, STAGGER=3, MAX_CYCLES=0, CNT_W=4, retire=1 continuously:
  - Releases at edges 5, 8, 11, 14.
  - No timeout; cycles and instret saturate at 15.
